// File: rtl/data_bus_master.sv
// rtl/data_bus_master.sv - initiator side of the shared data bus: request FIFO, bus sequencer, load return
module data_bus_master #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int IO_SEL_BIT     = 28
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic                      REQ_WE,
    input  logic [ADDR_BIT_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_BIT_WIDTH-1:0] REQ_WDATA,
    input  logic                      PIPE_FLUSH,
    output logic                      RSP_VALID,
    output logic [DATA_BIT_WIDTH-1:0] RSP_RDATA,
    output logic [ADDR_BIT_WIDTH-1:0] ABUS,
    inout  wire  [DATA_BIT_WIDTH-1:0] DBUS,
    output logic                      WE,
    output logic                      LOCK,
    output logic                      FLUSH
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // I/O space is decoded by the responders; the master only checks the bit exists.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IO_SEL_BIT >= ADDR_BIT_WIDTH) begin : g_bad_param
        $error("data_bus_master: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                    state_q, state_d;
    logic                      fifo_we   [FIFO_DEPTH];
    logic [ADDR_BIT_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_BIT_WIDTH-1:0] fifo_wdata[FIFO_DEPTH];
    logic [PTR_W-1:0]          head_q, tail_q, tail_m1;
    logic [CNT_W-1:0]          count_q;
    logic                      load_pending_q;
    logic                      push, pop, cancel, fifo_empty, fifo_full, load_in_fifo;
    logic [ADDR_BIT_WIDTH-1:0] abus_q;
    logic [DATA_BIT_WIDTH-1:0] dout_q, rdata_q;
    logic                      we_q, lock_q, flush_q, oe_q, rsp_valid_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign tail_m1    = tail_q - PTR_W'(1);
    // No pushes happen while a load is pending, so a queued load is always the tail entry.
    assign load_in_fifo = !fifo_empty && !fifo_we[tail_m1];
    assign cancel       = PIPE_FLUSH && load_in_fifo;
    assign pop          = !fifo_empty && !(cancel && count_q == CNT_W'(1));
    assign REQ_READY    = !fifo_full && !load_pending_q && !PIPE_FLUSH;
    assign push         = REQ_VALID && REQ_READY;

    always_comb begin
        state_d = IDLE;
        if (pop) begin
            state_d = fifo_we[head_q] ? WR : RD;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_we[tail_q]    <= REQ_WE;
            fifo_addr[tail_q]  <= REQ_ADDR;
            fifo_wdata[tail_q] <= REQ_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            load_pending_q <= 1'b0;
            abus_q         <= '0;
            dout_q         <= '0;
            we_q           <= 1'b0;
            lock_q         <= 1'b0;
            flush_q        <= 1'b1;
            oe_q           <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rdata_q        <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(push) - PTR_W'(cancel);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop) - CNT_W'(cancel);

            if (PIPE_FLUSH || state_q == RD) begin
                load_pending_q <= 1'b0;
            end else if (push && !REQ_WE) begin
                load_pending_q <= 1'b1;
            end

            if (pop) begin
                abus_q <= fifo_addr[head_q];
                dout_q <= fifo_wdata[head_q];
            end
            we_q    <= (state_d == WR);
            lock_q  <= (state_d == WR);
            oe_q    <= (state_d == WR);
            flush_q <= (state_d == IDLE);

            // A flush during the RD cycle lets the bus cycle finish but drops the response.
            rsp_valid_q <= (state_q == RD) && !PIPE_FLUSH;
            if (state_q == RD) begin
                rdata_q <= DBUS;
            end
        end
    end

    assign ABUS      = abus_q;
    assign WE        = we_q;
    assign LOCK      = lock_q;
    assign FLUSH     = flush_q;
    assign DBUS      = oe_q ? dout_q : 'z;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rdata_q;
endmodule

// File: tb/tb_data_bus_master.sv
// tb/tb_data_bus_master.sv - table-driven bench for data_bus_master with a simple word memory on the bus
module tb_data_bus_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, pipe_flush = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, we, lock, flush;
    logic [31:0] rsp_rdata, abus;
    wire  [31:0] dbus;

    pulldown pd_dbus (dbus);

    data_bus_master #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .FIFO_DEPTH(4), .IO_SEL_BIT(28)) dut (
        .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .PIPE_FLUSH(pipe_flush), .RSP_VALID(rsp_valid),
        .RSP_RDATA(rsp_rdata), .ABUS(abus), .DBUS(dbus), .WE(we), .LOCK(lock), .FLUSH(flush)
    );

    always #5 clk = ~clk;

    // Word memory answering only outside I/O space (ABUS[28]==0).
    logic [31:0] mem [16];
    wire mem_sel = !flush && !abus[28];
    assign dbus = (mem_sel && !we) ? mem[abus[5:2]] : 'z;
    always @(posedge clk) if (mem_sel && we && lock) mem[abus[5:2]] <= dbus;

    typedef struct {
        logic        v, w;
        logic [31:0] addr, wdata;
        logic        pf;
        logic        e_ready;
        logic [31:0] e_abus;
        logic        e_we, e_lock, e_flush, e_rsp;
        logic [31:0] e_rdata, e_dbus;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_chk = 0;

    task automatic row(input logic v, w, input logic [31:0] addr, wdata, input logic pf,
                       input logic rdy, input logic [31:0] ab, input logic bwe, blk, bfl, rsp,
                       input logic [31:0] rd, db);
        vec_t r;
        r.v = v; r.w = w; r.addr = addr; r.wdata = wdata; r.pf = pf;
        r.e_ready = rdy; r.e_abus = ab; r.e_we = bwe; r.e_lock = blk; r.e_flush = bfl;
        r.e_rsp = rsp; r.e_rdata = rd; r.e_dbus = db;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, w, input logic [31:0] a, d, input logic pf);
        req_valid = v; req_we = w; req_addr = a; req_wdata = d; pipe_flush = pf;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // store then load of the same word
        row(1,1,32'h10,32'hDEADBEEF,0, 1,32'h0,0,0,1, 0,32'h0,32'h0);
        row(1,0,32'h10,32'h0,0,       1,32'h0,0,0,1, 0,32'h0,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h10,1,1,0, 0,32'h0,32'hDEADBEEF);
        row(0,0,32'h0,32'h0,0,        0,32'h10,0,0,0, 0,32'h0,32'hDEADBEEF);
        row(0,0,32'h0,32'h0,0,        1,32'h10,0,0,1, 1,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        1,32'h10,0,0,1, 0,32'hDEADBEEF,32'h0);
        // five back-to-back stores: READY never drops
        for (int k = 0; k < 7; k++) begin
            logic [31:0] ea, ed;
            ea = (k < 2) ? ((k == 0) ? 32'h10 : 32'h10) : 32'h20 + 32'(4 * (k - 2));
            ed = 32'h11110000 + 32'(k - 2);
            row(k < 5, 1, 32'h20 + 32'(4 * k), 32'h11110000 + 32'(k), 0,
                1, ea, k >= 2, k >= 2, k < 2, 0, 32'hDEADBEEF, (k >= 2) ? ed : 32'h0);
        end
        row(0,0,32'h0,32'h0,0,        1,32'h30,0,0,1, 0,32'hDEADBEEF,32'h0);
        // three stores + load, flush while the load is still queued
        row(1,1,32'h40,32'hA0,0,      1,32'h30,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(1,1,32'h44,32'hA1,0,      1,32'h30,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(1,1,32'h48,32'hA2,0,      1,32'h40,1,1,0, 0,32'hDEADBEEF,32'hA0);
        row(1,0,32'h40,32'h0,0,       1,32'h44,1,1,0, 0,32'hDEADBEEF,32'hA1);
        row(0,0,32'h0,32'h0,1,        0,32'h48,1,1,0, 0,32'hDEADBEEF,32'hA2);
        row(0,0,32'h0,32'h0,0,        1,32'h48,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        1,32'h48,0,0,1, 0,32'hDEADBEEF,32'h0);
        // load from I/O space with no I/O responder: pulled-down bus
        row(1,0,32'h10000000,32'h0,0, 1,32'h48,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h48,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h10000000,0,0,0, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        1,32'h10000000,0,0,1, 1,32'h0,32'h0);
        // flush in the RD cycle: bus cycle runs, response suppressed
        row(1,0,32'h10,32'h0,0,       1,32'h10000000,0,0,1, 0,32'h0,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h10000000,0,0,1, 0,32'h0,32'h0);
        row(0,0,32'h0,32'h0,1,        0,32'h10,0,0,0, 0,32'h0,32'hDEADBEEF);
        row(0,0,32'h0,32'h0,0,        1,32'h10,0,0,1, 0,32'hDEADBEEF,32'h0);
        // flush in the response cycle: pulse survives; store offered with flush is refused
        row(1,0,32'h24,32'h0,0,       1,32'h10,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h10,0,0,1, 0,32'hDEADBEEF,32'h0);
        row(0,0,32'h0,32'h0,0,        0,32'h24,0,0,0, 0,32'hDEADBEEF,32'h11110001);
        row(1,1,32'h2C,32'h99,1,      0,32'h24,0,0,1, 1,32'h11110001,32'h0);
        row(0,0,32'h0,32'h0,0,        1,32'h24,0,0,1, 0,32'h11110001,32'h0);
        row(0,0,32'h0,32'h0,0,        1,32'h24,0,0,1, 0,32'h11110001,32'h0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].pf);
            #1;
            n_vec++;
            chk("ready", i, 32'(req_ready), 32'(tbl[i].e_ready));
            chk("abus",  i, abus,           tbl[i].e_abus);
            chk("we",    i, 32'(we),        32'(tbl[i].e_we));
            chk("lock",  i, 32'(lock),      32'(tbl[i].e_lock));
            chk("flush", i, 32'(flush),     32'(tbl[i].e_flush));
            chk("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].e_rsp));
            chk("rsp_rdata", i, rsp_rdata,  tbl[i].e_rdata);
            chk("dbus",  i, dbus,           tbl[i].e_dbus);
        end
        chk("mem_word4", 0, mem[4], 32'hDEADBEEF);
        chk("mem_word11", 0, mem[11], 32'h11110003);

        // reset asserted in the middle of a store burst
        @(negedge clk); drive(1,1,32'h14,32'hCAFE0001,0);
        @(negedge clk); drive(1,1,32'h18,32'hCAFE0002,0);
        @(negedge clk); drive(1,1,32'h1C,32'hCAFE0003,0);
        #1;
        n_vec++;
        chk("burst_we", 100, 32'(we), 32'd1);
        chk("burst_dbus", 100, dbus, 32'hCAFE0001);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_flush", 101, 32'(flush), 32'd1);
        chk("rst_we",    101, 32'(we), 32'd0);
        chk("rst_lock",  101, 32'(lock), 32'd0);
        chk("rst_dbus",  101, dbus, 32'h0);
        drive(0,0,32'h0,32'h0,0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            chk("post_rst_ready", 102 + i, 32'(req_ready), 32'd1);
            chk("post_rst_flush", 102 + i, 32'(flush), 32'd1);
            chk("post_rst_we",    102 + i, 32'(we), 32'd0);
            chk("post_rst_abus",  102 + i, abus, 32'h0);
            chk("post_rst_rsp",   102 + i, 32'(rsp_valid), 32'd0);
            chk("post_rst_rdata", 102 + i, rsp_rdata, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
